// File: rtl/rib_arbiter_if.sv
// rib_arbiter_if: request/grant bundle between the rib masters and the arbiter
interface rib_arbiter_if #(parameter int N = 4);
   logic [N-1:0]         i_req;
   logic [N-1:0]         o_gnt;
   logic                 o_gnt_vld;
   logic [$clog2(N)-1:0] o_gnt_id;
   logic [N-1:0]         o_bus_halt;
   modport slave (input i_req, output o_gnt, o_gnt_vld, o_gnt_id, o_bus_halt);
   modport master (output i_req, input o_gnt, o_gnt_vld, o_gnt_id, o_bus_halt);
endinterface

// File: rtl/rib_arbiter.sv
// rib_arbiter: registered rib bus arbiter, strict-priority debug master plus round-robin with bounded hold
module rib_arbiter #(
   parameter int MASTER_NUM  = 4,
   parameter int MAX_HOLD    = 8,
   parameter int PRIO_MASTER = 2
) (
   input logic          clk,
   input logic          rst,
   rib_arbiter_if.slave bus
);
   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [1:0] PID = 2'(PRIO_MASTER);
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
   typedef enum logic {IDLE, OWNED} state_t;
   state_t                state_q;
   logic [MASTER_NUM-1:0] gnt_q;
   logic                  vld_q;
   logic [1:0]            id_q;
   logic [1:0]            rr_q;
   logic [HW-1:0]         hold_q;
   logic [1:0]            win;
   logic                  others, hit, take_d, drop_d;
   // winner: debug master first, otherwise first requester after rr_q with wrap
   always_comb begin
      win = rr_q;
      for (int k = MASTER_NUM - 1; k >= 0; k--)
         if (bus.i_req[rr_q + 2'(k + 1)]) win = rr_q + 2'(k + 1);
      win = bus.i_req[PID] ? PID : win;
   end
   // decide whether this edge hands the bus to a new owner or releases it
   always_comb begin
      others = |(bus.i_req & ~gnt_q);
      hit    = bus.i_req[id_q];
      take_d = (state_q == OWNED)
             ? (!hit && others) || (hit && id_q != PID && (bus.i_req[PID] || (hold_q == HMAX && others)))
             : |bus.i_req;
      drop_d = state_q == OWNED && !hit && !others;
   end
   // ownership FSM with registered grant outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         id_q    <= 2'd0;
         hold_q  <= '0;
         rr_q    <= 2'd3;
      end else if (take_d) begin
         state_q <= OWNED;
         gnt_q   <= {{(MASTER_NUM-1){1'b0}}, 1'b1} << win;
         vld_q   <= 1'b1;
         id_q    <= win;
         hold_q  <= '0;
         rr_q    <= win;
      end else if (drop_d) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         id_q    <= 2'd0;
         hold_q  <= '0;
      end else if (state_q == OWNED && hold_q != HMAX) begin
         hold_q  <= hold_q + 1'b1;
      end
   end
   assign bus.o_gnt      = gnt_q;
   assign bus.o_gnt_vld  = vld_q;
   assign bus.o_gnt_id   = id_q;
   assign bus.o_bus_halt = bus.i_req & ~gnt_q;
endmodule
